// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: pipeline MEM stage with a req/gnt/rvalid data bus, MEM/WB register, EX forwarding and
// WB-stall result buffer. Optional define MEM_MISALIGN_TRAP_EN adds the oMisalign trap. Rev 1.0
module mem_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iStall,
  input  logic                      iValid,
  input  logic                      iMemRead,
  input  logic                      iMemWrite,
  input  logic [2:0]                iFunc3,
  input  logic                      iRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] iRd,
  input  logic [REG_WIDTH-1:0]      iAddr,
  input  logic [REG_WIDTH-1:0]      iStoreData,
  output logic                      oReq,
  output logic                      oWe,
  output logic [REG_WIDTH-1:0]      oAddr,
  output logic [REG_WIDTH-1:0]      oWData,
  output logic [3:0]                oBe,
  input  logic                      iGnt,
  input  logic                      iRValid,
  input  logic [REG_WIDTH-1:0]      iRData,
  output logic                      oStallReq,
  output logic                      oWbValid,
  output logic                      oWbRegWrite,
  output logic [REG_ADDR_WIDTH-1:0] oWbRd,
  output logic [REG_WIDTH-1:0]      oWbData,
  output logic [REG_WIDTH-1:0]      oFwMe,
  output logic [REG_ADDR_WIDTH-1:0] oFwMeRd,
  output logic                      oFwMeEn
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      oMisalign
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]           state, state_nxt;
  logic                 memop, memop_eff, is_byte, is_half, mis;
  logic                 req, complete, capture, stall_req;
  logic [1:0]           lane_shift;
  logic [3:0]           be;
  logic [REG_WIDTH-1:0] wdata, shifted, load_data, mem_result, buf_data;
  logic                 mis_q;

  assign memop   = iValid & (iMemRead | iMemWrite);
  assign is_byte = (iFunc3[1:0] == 2'b00);
  assign is_half = (iFunc3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = memop & ((is_half & iAddr[0]) | (!is_byte && !is_half && (iAddr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif
  assign memop_eff = memop & ~mis;

  // Halves only look at addr[1] and words are forced aligned, so odd offsets never shift past a lane.
  always_comb begin
    lane_shift = 2'b00;
    be         = 4'hF;
    wdata      = iStoreData;
    if (is_byte) begin
      lane_shift = iAddr[1:0];
      be         = 4'b0001 << iAddr[1:0];
      wdata      = {4{iStoreData[7:0]}};
    end else if (is_half) begin
      lane_shift = {iAddr[1], 1'b0};
      be         = 4'b0011 << {iAddr[1], 1'b0};
      wdata      = {2{iStoreData[15:0]}};
    end
  end

  assign shifted = iRData >> {lane_shift, 3'b000};

  always_comb begin
    case (iFunc3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (memop_eff && !iStall) begin
          if (!iGnt)           state_nxt = S_REQ;
          else if (!iMemWrite) state_nxt = S_WAIT_R;
        end
      end
      S_REQ: begin
        if (iGnt) begin
          if (!iMemWrite)  state_nxt = S_WAIT_R;
          else if (iStall) state_nxt = S_HOLD;
          else             state_nxt = S_IDLE;
        end
      end
      S_WAIT_R: begin
        if (iRValid) state_nxt = iStall ? S_HOLD : S_IDLE;
      end
      default: begin
        if (!iStall) state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req        = 1'b0;
    complete   = 1'b0;
    capture    = 1'b0;
    mem_result = iAddr;
    case (state)
      S_IDLE: begin
        req      = memop_eff & ~iStall;
        complete = memop_eff & ~iStall & iGnt & iMemWrite;
      end
      S_REQ: begin
        req      = 1'b1;
        complete = iGnt & iMemWrite & ~iStall;
        capture  = iGnt & iMemWrite & iStall;
      end
      S_WAIT_R: begin
        mem_result = load_data;
        complete   = iRValid & ~iStall;
        capture    = iRValid & iStall;
      end
      default: begin
        mem_result = buf_data;
        complete   = ~iStall;
      end
    endcase
    stall_req = ((state == S_IDLE) ? memop_eff : 1'b1) & ~complete;
  end

  // Comb outputs are gated during reset so every output reads 0 while iRst is high.
  assign oReq      = req & ~iRst;
  assign oStallReq = stall_req & ~iRst;
  assign oWe       = oReq & iMemWrite;
  assign oAddr     = oReq ? {iAddr[REG_WIDTH-1:2], 2'b00} : '0;
  assign oBe       = oReq ? be : 4'h0;
  assign oWData    = oWe ? wdata : '0;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         buf_data <= '0;
    else if (capture) buf_data <= mem_result;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oWbValid    <= 1'b0;
      oWbRegWrite <= 1'b0;
      oWbRd       <= '0;
      oWbData     <= '0;
      mis_q       <= 1'b0;
    end else if (!iStall) begin
      if (complete) begin
        oWbValid    <= 1'b1;
        oWbRegWrite <= iRegWrite & ~iMemWrite;
        oWbRd       <= iRd;
        oWbData     <= mem_result;
        mis_q       <= 1'b0;
      end else if (state == S_IDLE && iValid && !memop_eff) begin
        oWbValid    <= 1'b1;
        oWbRegWrite <= iRegWrite & ~mis;
        oWbRd       <= iRd;
        oWbData     <= iAddr;
        mis_q       <= mis;
      end else begin
        oWbValid    <= 1'b0;
        oWbRegWrite <= 1'b0;
        mis_q       <= 1'b0;
      end
    end
  end

  assign oFwMe   = oWbData;
  assign oFwMeRd = oWbRd;
  assign oFwMeEn = oWbValid & oWbRegWrite & (oWbRd != '0);

`ifdef MEM_MISALIGN_TRAP_EN
  assign oMisalign = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, valid, mem_read, mem_write, reg_write, gnt, rvalid;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [31:0] addr, store_data, rdata;
  logic        req, we, stall_req, wb_valid, wb_reg_write, fw_en;
  logic [31:0] mem_addr, wdata, wb_data, fw_data;
  logic [3:0]  be;
  logic [4:0]  wb_rd, fw_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .iClk(clk), .iRst(rst), .iStall(stall), .iValid(valid),
    .iMemRead(mem_read), .iMemWrite(mem_write), .iFunc3(func3),
    .iRegWrite(reg_write), .iRd(rd), .iAddr(addr), .iStoreData(store_data),
    .oReq(req), .oWe(we), .oAddr(mem_addr), .oWData(wdata), .oBe(be),
    .iGnt(gnt), .iRValid(rvalid), .iRData(rdata), .oStallReq(stall_req),
    .oWbValid(wb_valid), .oWbRegWrite(wb_reg_write), .oWbRd(wb_rd),
    .oWbData(wb_data), .oFwMe(fw_data), .oFwMeRd(fw_rd), .oFwMeEn(fw_en)
`ifdef MEM_MISALIGN_TRAP_EN
    , .oMisalign(misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; mem_read = 0; mem_write = 0; reg_write = 0; gnt = 0; rvalid = 0; stall = 0;
  endtask

  // Load with immediate grant and read data one cycle later.
  task automatic load_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] dst, input logic [31:0] rd_word, input logic [31:0] exp);
    valid = 1; mem_read = 1; mem_write = 0; reg_write = 1; func3 = f3; addr = a; rd = dst; gnt = 1;
    #1;
    check({tag, "_req"}, {31'd0, req}, 32'd1);
    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    tick();
    gnt = 0; rvalid = 1; rdata = rd_word;
    #1;
    check({tag, "_stall_lo"}, {31'd0, stall_req}, 32'd0);
    tick();
    rvalid = 0; valid = 0; mem_read = 0;
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_fw_en"}, {31'd0, fw_en}, 32'd1);
  endtask

  initial begin
    rst = 1; idle_inputs(); func3 = 0; rd = 0; addr = 0; store_data = 0; rdata = 0;
    valid = 1; mem_read = 1;
    tick(); tick();
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    idle_inputs();
    rst = 0;
    tick();

    // ALU result passes straight to MEM/WB
    valid = 1; addr = 32'h1234; rd = 5; reg_write = 1;
    #1;
    check("add_no_req", {31'd0, req}, 32'd0);
    check("add_no_stall", {31'd0, stall_req}, 32'd0);
    tick();
    check("add_wb_data", wb_data, 32'h1234);
    check("add_fw_data", fw_data, 32'h1234);
    check("add_fw_rd", {27'd0, fw_rd}, 32'd5);
    check("add_fw_en", {31'd0, fw_en}, 32'd1);
    valid = 0; reg_write = 0;
    tick();
    check("bubble_valid", {31'd0, wb_valid}, 32'd0);
    check("bubble_fw_en", {31'd0, fw_en}, 32'd0);

    // SB with grant held off for three cycles
    valid = 1; mem_write = 1; func3 = 3'b000; addr = 32'h1003; store_data = 32'h1234_56AB; rd = 0;
    for (int i = 0; i < 4; i++) begin
      gnt = (i == 3);
      #1;
      check($sformatf("sb_req%0d", i), {31'd0, req}, 32'd1);
      check($sformatf("sb_be%0d", i), {28'd0, be}, 32'h8);
      check($sformatf("sb_wdata%0d", i), wdata, 32'hABAB_ABAB);
      check($sformatf("sb_stall%0d", i), {31'd0, stall_req}, (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    idle_inputs();
    check("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sb_wb_regwrite", {31'd0, wb_reg_write}, 32'd0);
    #1;
    check("sb_req_done", {31'd0, req}, 32'd0);

    // SH on upper half with immediate grant
    valid = 1; mem_write = 1; func3 = 3'b001; addr = 32'h2002; store_data = 32'h0000_BEEF; gnt = 1;
    #1;
    check("sh_be", {28'd0, be}, 32'hC);
    check("sh_wdata", wdata, 32'hBEEF_BEEF);
    check("sh_we", {31'd0, we}, 32'd1);
    tick();
    idle_inputs();

    load_imm("lh", 3'b001, 32'h2002, 5'd7, 32'h8001_0000, 32'hFFFF_8001);
    load_imm("lhu", 3'b101, 32'h2002, 5'd7, 32'h8001_0000, 32'h0000_8001);
    load_imm("lb", 3'b000, 32'h1001, 5'd3, 32'h0000_8000, 32'hFFFF_FF80);
    load_imm("lbu", 3'b100, 32'h1003, 5'd3, 32'hF100_0000, 32'h0000_00F1);
    load_imm("lw", 3'b010, 32'h4000, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Read data arrives while WB is stalled
    valid = 1; mem_read = 1; func3 = 3'b010; addr = 32'h5000; rd = 9; reg_write = 1; gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 32'h55; stall = 1;
    #1;
    check("hold_stallreq", {31'd0, stall_req}, 32'd1);
    tick();
    rvalid = 0; rdata = 32'h0;
    check("hold_data1", wb_data, 32'hDEAD_BEEF);
    tick();
    check("hold_data2", wb_data, 32'hDEAD_BEEF);
    check("hold_rd", {27'd0, wb_rd}, 32'd8);
    stall = 0;
    #1;
    check("hold_release_stall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_inputs();
    check("hold_data_out", wb_data, 32'h55);
    check("hold_rd_out", {27'd0, wb_rd}, 32'd9);

    // Reset while waiting for read data
    valid = 1; mem_read = 1; func3 = 3'b010; addr = 32'h6000; rd = 10; gnt = 1;
    tick();
    gnt = 0; rst = 1;
    #1;
    check("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rstw_wb_data", wb_data, 32'd0);
    check("rstw_req", {31'd0, req}, 32'd0);
    check("rstw_stall", {31'd0, stall_req}, 32'd0);
    idle_inputs();
    #1;
    rst = 0; rvalid = 1; rdata = 32'h77;
    tick();
    rvalid = 0;
    check("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
    check("rstw_no_data", wb_data, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    valid = 1; mem_read = 1; func3 = 3'b010; addr = 32'h3001; rd = 4; reg_write = 1; gnt = 1;
    #1;
    check("mis_req", {31'd0, req}, 32'd0);
    check("mis_stall", {31'd0, stall_req}, 32'd0);
    tick();
    idle_inputs();
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_regwrite", {31'd0, wb_reg_write}, 32'd0);
    check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    tick();
    check("mis_flag_clr", {31'd0, misalign}, 32'd0);
`else
    load_imm("lw_unaligned", 3'b010, 32'h3001, 5'd4, 32'h1122_3344, 32'h1122_3344);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Consumes the EX/MEM register contents (ALU result, store data, control) and performs loads and stores over a req/gnt/rvalid data-memory bus.
- Registers the MEM/WB result and drives the MEM-stage forwarding value back to EX.
- Requests a pipeline stall while a memory transaction is outstanding.
- Buffers a completed result while WB is stalled.

Parameters:
- RegWidth, 32, datapath/register width; must be 32.
- RegAddrWidth, 5, register index width.

Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-high reset.
- iStall  in  1  downstream (WB) hold; MEM/WB register must not update.
- iValid  in  1  EX/MEM register holds a valid instruction.
- iMemRead  in  1  instruction is a load.
- iMemWrite  in  1  instruction is a store.
- iFunc3  in  3  RV32 load/store width/sign code.
- iRegWrite  in  1  instruction writes rd.
- iRd  in  5  destination register.
- iAddr  in  32  ALU result (effective address, or result for non-memory ops).
- iStoreData  in  32  rs2 value for stores.
- oReq  out  1  memory request.
- oWe  out  1  write enable, qualified by oReq.
- oAddr  out  32  word-aligned address ({iAddr[31:2],2'b00}).
- oWData  out  32  lane-replicated store data.
- oBe  out  4  byte enables.
- iGnt  in  1  request accepted this cycle.
- iRValid  in  1  read data valid.
- iRData  in  32  read word.
- oStallReq  out  1  hold IF/ID/EX and the EX/MEM register.
- oWbValid  out  1  MEM/WB register valid.
- oWbRegWrite  out  1  write back enabled.
- oWbRd  out  5  write-back register index.
- oWbData  out  32  write-back value.
- oFwMe  out  32  forwarding value (equals oWbData).
- oFwMeRd  out  5  forwarding register index.
- oFwMeEn  out  1  forwarding valid.

Behaviour:
- Reset: async on iRst high. State=IDLE. All outputs 0, including oReq, oStallReq and every oWb*/oFwMe*. Any in-flight transaction is abandoned. iRValid arriving after reset is ignored because IDLE never samples it.
- Memory op (memop) is defined as iValid & (iMemRead | iMemWrite).
- FSM states:
  - IDLE: oReq = memop & !iStall, combinational.
    - Non-memop with !iStall: MEM/WB register loads iAddr, iRd, iRegWrite and valid in one cycle.
    - Store with iGnt: complete this cycle and write MEM/WB (regwrite=0).
    - Store without iGnt: go to REQ.
    - Load with iGnt: go to WAIT_R.
    - Load without iGnt: go to REQ.
  - REQ: oReq=1, with oAddr/oWe/oBe/oWData held from the EX/MEM register, which is stalled.
    - On iGnt, a store completes and a load goes to WAIT_R.
  - WAIT_R: oReq=0. On iRValid, capture the aligned/extended data.
    - If !iStall, write MEM/WB and go to IDLE; otherwise go to HOLD.
  - HOLD: result sits in an internal buffer. When iStall drops, write MEM/WB and go to IDLE.
- oStallReq = memop & !(completion this cycle), covering IDLE issue, REQ, WAIT_R and HOLD. It is deasserted exactly in the completion cycle so that EX/MEM advances.
- Latency:
  - Non-memop: 1 cycle to oWb*.
  - Load with immediate gnt and rvalid the next cycle: data visible at oWbData 2 cycles after presentation.
- Store lanes:
  - SB: oBe = 1<<iAddr[1:0], data {4{b}}.
  - SH: oBe = 4'b0011<<{iAddr[1],1'b0}, data {2{h}}.
  - SW: oBe = 4'hF.
- Load extract: shift iRData right by iAddr[1:0]*8, then extend by func3:
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW: no extension.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - Other func3: treat as LW.
- Forwarding: oFwMe=oWbData, oFwMeRd=oWbRd, oFwMeEn = oWbValid & oWbRegWrite & (oWbRd!=0).
- iStall with no completion pending: MEM/WB holds, and an IDLE memop does not issue.
- Bubble: !iValid & !iStall writes oWbValid=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN. Adds output oMisalign (1 bit, reset 0).
- With the macro: a half access with iAddr[0]=1, or a word access with iAddr[1:0]!=0, issues no request and completes in IDLE like a non-memop, with oWbRegWrite forced 0 and oMisalign=1 for that one MEM/WB cycle.
- Without the macro: the low address bits are silently ignored and no trap is raised.
  - Half accesses use iAddr[1] only.
  - Word accesses are forced aligned.

Test Plan:
- ADD result: iValid=1, non-memop, iAddr=0x1234, iRd=5, iRegWrite=1 -> next cycle oWbData=0x1234, oFwMeEn=1, oFwMeRd=5, oReq never asserted.
- SB: iAddr=0x1003, data=0xAB, iGnt held low 3 cycles then high -> oReq high 4 cycles, oBe=4'b1000, oWData=0xABABABAB, oStallReq high 3 cycles and low on the gnt cycle.
- LH: iAddr=0x2002, gnt immediate, iRData=0x8001_0000 one cycle later -> oWbData=0xFFFF8001. Repeat as LHU -> oWbData=0x00008001.
- Load with iStall=1 during iRValid (iRData=0x55): MEM/WB unchanged while iStall is high. After iStall drops -> oWbData=0x55 the next cycle.
- iRst asserted while in WAIT_R, then iRValid pulsed -> all outputs 0, state IDLE, no write-back occurs.
- With MEM_MISALIGN_TRAP_EN: LW at 0x3001 -> oReq=0, oMisalign=1 for one cycle, oWbRegWrite=0.
